// File: rtl/qtcore_scan_pkg.sv
// qtcore_scan_pkg: shared types and constants for the qtcore scan sequencer.
package qtcore_scan_pkg;
    localparam int BYTE_W        = 8;
    localparam int CHAIN_LEN_DEF = 256;
    typedef enum logic [1:0] {IDLE, SHIFT, RUN} state_e;
endpackage

// File: rtl/qtcore_scan_sequencer_if.sv
// qtcore_scan_sequencer_if: host command/stream and core scan/proc signals of the sequencer.
interface qtcore_scan_sequencer_if #(parameter int CYC_W = 16);
    logic                               cmd_load;
    logic                               cmd_run;
    logic                               busy;
    logic                               in_valid;
    logic                               in_ready;
    logic [qtcore_scan_pkg::BYTE_W-1:0] in_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [qtcore_scan_pkg::BYTE_W-1:0] out_data;
    logic                               scan_enable;
    logic                               scan_in;
    logic                               scan_out;
    logic                               proc_en;
    logic                               halt;
    logic                               load_done;
    logic                               run_done;
    logic                               timeout;
    logic [CYC_W-1:0]                   cycle_count;
    modport master (
        output cmd_load, cmd_run, in_valid, in_data, out_ready, scan_out, halt,
        input  busy, in_ready, out_valid, out_data, scan_enable, scan_in, proc_en,
               load_done, run_done, timeout, cycle_count
    );
    modport slave (
        input  cmd_load, cmd_run, in_valid, in_data, out_ready, scan_out, halt,
        output busy, in_ready, out_valid, out_data, scan_enable, scan_in, proc_en,
               load_done, run_done, timeout, cycle_count
    );
endinterface

// File: rtl/scan_byte_serdes.sv
// scan_byte_serdes: byte-wide serialiser into the scan chain and deserialiser of the displaced bits.
module scan_byte_serdes
    import qtcore_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_active,
    input  logic              i_in_valid,
    input  logic [BYTE_W-1:0] i_in_data,
    input  logic              i_out_ready,
    input  logic              i_scan_out,
    output logic              o_in_ready,
    output logic              o_scan_enable,
    output logic              o_scan_in,
    output logic              o_out_valid,
    output logic [BYTE_W-1:0] o_out_data,
    output logic              o_byte_end
);
    localparam int IW = $clog2(BYTE_W);
    logic [IW-1:0]     r_bit_idx;
    logic [BYTE_W-1:0] r_tx;
    logic [BYTE_W-1:0] r_rx;
    logic [BYTE_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              w_first;
    assign w_first       = r_bit_idx == '0;
    // A new byte is only taken once the previous readback has a free slot.
    assign o_in_ready    = i_active && w_first && (!r_out_valid || i_out_ready);
    assign o_scan_enable = w_first ? i_in_valid && o_in_ready : i_active;
    assign o_scan_in     = o_scan_enable && (w_first ? i_in_data[0] : r_tx[r_bit_idx]);
    assign o_byte_end    = o_scan_enable && r_bit_idx == IW'(BYTE_W - 1);
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_idx   <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (o_scan_enable) begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_rx      <= {i_scan_out, r_rx[BYTE_W-1:1]};
            end
            if (o_scan_enable && w_first)
                r_tx <= i_in_data;
            if (o_byte_end) begin
                r_out_data  <= {i_scan_out, r_rx[BYTE_W-1:1]};
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/qtcore_scan_sequencer.sv
// qtcore_scan_sequencer: loads the core scan chain from a byte stream, returns the displaced
// contents, and runs the core until halt or a cycle limit.
module qtcore_scan_sequencer
    import qtcore_scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int RUN_LIMIT = 65535,
    parameter int CYC_W     = 16
) (
    input logic                    clk,
    input logic                    rst,
    qtcore_scan_sequencer_if.slave bus
);
    localparam int NB  = CHAIN_LEN / BYTE_W;
    localparam int BIW = NB > 1 ? $clog2(NB) : 1;
    state_e           r_state;
    state_e           w_state_nx;
    logic [BIW-1:0]   r_byte_idx;
    logic [CYC_W-1:0] r_cycle_count;
    logic             r_proc_en;
    logic             r_load_done;
    logic             r_run_done;
    logic             r_timeout;
    logic             w_byte_end;
    logic             w_last;
    logic             w_go_load;
    logic             w_go_run;
    logic             w_stop_halt;
    logic             w_stop_lim;
    scan_byte_serdes u_serdes (
        .clk          (clk),
        .rst          (rst),
        .i_active     (r_state == SHIFT),
        .i_in_valid   (bus.in_valid),
        .i_in_data    (bus.in_data),
        .i_out_ready  (bus.out_ready),
        .i_scan_out   (bus.scan_out),
        .o_in_ready   (bus.in_ready),
        .o_scan_enable(bus.scan_enable),
        .o_scan_in    (bus.scan_in),
        .o_out_valid  (bus.out_valid),
        .o_out_data   (bus.out_data),
        .o_byte_end   (w_byte_end)
    );
    assign w_last      = w_byte_end && r_byte_idx == BIW'(NB - 1);
    assign w_go_load   = r_state == IDLE && bus.cmd_load;
    assign w_go_run    = r_state == IDLE && bus.cmd_run && !bus.cmd_load;
    // proc_en is only ever high inside RUN, so these need no state qualifier.
    assign w_stop_halt = r_proc_en && bus.halt;
    assign w_stop_lim  = r_proc_en && r_cycle_count == CYC_W'(RUN_LIMIT - 1);
    always_comb begin
        w_state_nx = r_state;
        w_state_nx = w_go_load ? SHIFT :
                     w_go_run ? RUN :
                     (w_last || w_stop_halt || w_stop_lim) ? IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_idx    <= '0;
            r_cycle_count <= '0;
            r_proc_en     <= 1'b0;
            r_load_done   <= 1'b0;
            r_run_done    <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_byte_idx    <= w_last ? '0 : w_byte_end ? r_byte_idx + 1'b1 : r_byte_idx;
            r_proc_en     <= r_state == RUN && !w_stop_halt && !w_stop_lim;
            r_cycle_count <= w_go_run ? '0 : r_proc_en ? r_cycle_count + 1'b1 : r_cycle_count;
            r_load_done   <= w_last;
            r_run_done    <= w_stop_halt;
            r_timeout     <= w_stop_lim && !w_stop_halt;
        end
    end
    assign bus.busy        = r_state != IDLE;
    assign bus.proc_en     = r_proc_en;
    assign bus.load_done   = r_load_done;
    assign bus.run_done    = r_run_done;
    assign bus.timeout     = r_timeout;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_qtcore_scan_sequencer.sv
// tb_qtcore_scan_sequencer: directed scenarios against a 16-bit core scan chain model.
module tb_qtcore_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] chain = 16'hC35A;
    int          checks = 0;
    int          fails = 0;
    int          se_cnt, rb_n, ld_cycle, stall_se, pe_seen;
    logic [15:0] si_bits;
    logic [7:0]  rb [2];
    logic [31:0] rst_snap;
    int          pn, rd, to, done_c, conflict;
    logic [15:0] cc_done;
    logic        pe_after;

    always #5 clk = ~clk;

    qtcore_scan_sequencer_if #(.CYC_W(16)) bus ();
    qtcore_scan_sequencer #(.CHAIN_LEN(16), .RUN_LIMIT(20), .CYC_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Core chain: scan_in enters at the top, scan_out is the bottom bit.
    assign bus.scan_out = chain[0];
    always @(posedge clk) if (bus.scan_enable) chain <= {bus.scan_in, chain[15:1]};

    function automatic logic [31:0] snap();
        return {bus.busy, bus.in_ready, bus.out_valid, bus.out_data, bus.scan_enable, bus.scan_in,
                bus.proc_en, bus.load_done, bus.run_done, bus.timeout, bus.cycle_count};
    endfunction

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input bit both,
                           input int vs, input int vl, input int os, input int ol, input int rst_at);
        logic [7:0] bytes [2];
        int idx;
        bit acc;
        bytes[0] = b0; bytes[1] = b1; idx = 0;
        se_cnt = 0; rb_n = 0; ld_cycle = -1; stall_se = 0; pe_seen = 0; si_bits = '0;
        rb[0] = '0; rb[1] = '0; rst_snap = '1;
        @(posedge clk); #1;
        bus.cmd_load = 1'b1; bus.cmd_run = both;
        @(posedge clk); #1;
        bus.cmd_load = 1'b0; bus.cmd_run = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.in_valid  = !(c >= vs && c < vs + vl);
            bus.out_ready = !(c >= os && c < os + ol);
            bus.in_data   = idx < 2 ? bytes[idx] : 8'h00;
            if (c == rst_at) begin
                #2; rst = 1'b1;
                #1; rst_snap = snap();
                @(negedge clk); rst = 1'b0;
                break;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (bus.scan_enable) begin
                if (se_cnt < 16) si_bits[se_cnt] = bus.scan_in;
                se_cnt++;
                if ((c >= vs && c < vs + vl) || (c >= os && c < os + ol)) stall_se++;
            end
            if (bus.proc_en) pe_seen++;
            if (bus.out_valid && bus.out_ready) begin
                if (rb_n < 2) rb[rb_n] = bus.out_data;
                rb_n++;
            end
            if (bus.load_done && ld_cycle < 0) ld_cycle = c;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    endtask

    task automatic do_run(input int halt_at);
        pn = 0; rd = 0; to = 0; done_c = -1; conflict = 0; cc_done = '1; pe_after = 1'b1;
        @(posedge clk); #1; bus.cmd_run = 1'b1;
        @(posedge clk); #1; bus.cmd_run = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.proc_en) pn++;
            bus.halt = bus.proc_en && pn == halt_at;
            @(negedge clk);
            if (bus.proc_en && bus.scan_enable) conflict++;
            if (bus.run_done) rd++;
            if (bus.timeout) to++;
            if ((bus.run_done || bus.timeout) && done_c < 0) begin
                done_c = c; cc_done = bus.cycle_count; pe_after = bus.proc_en;
            end
            @(posedge clk); #1;
            if (done_c >= 0 && c > done_c + 2) break;
        end
        bus.halt = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (snap() !== 32'h0) begin fails++; $display("FAIL reset_outputs got=%h want=%h", snap(), 32'h0); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_idle busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_load_basic();
        do_load(8'hA5, 8'h3C, 1'b0, 100, 0, 100, 0, -1);
        checks++; if (se_cnt != 16) begin fails++; $display("FAIL load_se_count got=%0d want=16", se_cnt); end
        checks++; if (si_bits !== 16'h3CA5) begin fails++; $display("FAIL load_scan_in got=%h want=3ca5", si_bits); end
        checks++; if (ld_cycle != 16) begin fails++; $display("FAIL load_done_cycle got=%0d want=16", ld_cycle); end
        checks++; if (rb_n != 2) begin fails++; $display("FAIL load_rb_count got=%0d want=2", rb_n); end
        checks++; if (rb[0] !== 8'h5A) begin fails++; $display("FAIL load_rb0 got=%h want=5a", rb[0]); end
        checks++; if (rb[1] !== 8'hC3) begin fails++; $display("FAIL load_rb1 got=%h want=c3", rb[1]); end
    endtask

    task automatic test_in_stall();
        do_load(8'h81, 8'h7E, 1'b0, 8, 5, 100, 0, -1);
        checks++; if (se_cnt != 16) begin fails++; $display("FAIL install_se_count got=%0d want=16", se_cnt); end
        checks++; if (stall_se != 0) begin fails++; $display("FAIL install_se_in_stall got=%0d want=0", stall_se); end
        checks++; if (si_bits !== 16'h7E81) begin fails++; $display("FAIL install_scan_in got=%h want=7e81", si_bits); end
        checks++; if (ld_cycle != 21) begin fails++; $display("FAIL install_done_cycle got=%0d want=21", ld_cycle); end
        checks++; if (rb[0] !== 8'hA5 || rb[1] !== 8'h3C || rb_n != 2) begin
            fails++; $display("FAIL install_rb got=%h,%h n=%0d want=a5,3c n=2", rb[0], rb[1], rb_n); end
    endtask

    task automatic test_out_stall();
        do_load(8'h0F, 8'hF0, 1'b0, 100, 0, 8, 3, -1);
        checks++; if (se_cnt != 16) begin fails++; $display("FAIL outstall_se_count got=%0d want=16", se_cnt); end
        checks++; if (stall_se != 0) begin fails++; $display("FAIL outstall_se_in_stall got=%0d want=0", stall_se); end
        checks++; if (si_bits !== 16'hF00F) begin fails++; $display("FAIL outstall_scan_in got=%h want=f00f", si_bits); end
        checks++; if (ld_cycle != 19) begin fails++; $display("FAIL outstall_done_cycle got=%0d want=19", ld_cycle); end
        checks++; if (rb[0] !== 8'h81 || rb[1] !== 8'h7E || rb_n != 2) begin
            fails++; $display("FAIL outstall_rb got=%h,%h n=%0d want=81,7e n=2", rb[0], rb[1], rb_n); end
    endtask

    task automatic test_halt_idle();
        bus.halt = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.run_done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL halt_idle run_done=%b busy=%b want 0,0", bus.run_done, bus.busy); end
        bus.halt = 1'b0;
    endtask

    task automatic test_run_halt();
        do_run(10);
        checks++; if (rd != 1 || to != 0) begin fails++; $display("FAIL halt_pulses run_done=%0d timeout=%0d want 1,0", rd, to); end
        checks++; if (cc_done !== 16'd10) begin fails++; $display("FAIL halt_cycle_count got=%0d want=10", cc_done); end
        checks++; if (pe_after !== 1'b0) begin fails++; $display("FAIL halt_proc_en_after got=%b want=0", pe_after); end
        checks++; if (pn != 10) begin fails++; $display("FAIL halt_pe_cycles got=%0d want=10", pn); end
        checks++; if (bus.cycle_count !== 16'd10) begin fails++; $display("FAIL halt_count_held got=%0d want=10", bus.cycle_count); end
    endtask

    task automatic test_run_timeout();
        do_run(0);
        checks++; if (to != 1 || rd != 0) begin fails++; $display("FAIL timeout_pulses run_done=%0d timeout=%0d want 0,1", rd, to); end
        checks++; if (cc_done !== 16'd20) begin fails++; $display("FAIL timeout_cycle_count got=%0d want=20", cc_done); end
        checks++; if (pn != 20 || conflict != 0) begin fails++; $display("FAIL timeout_pe_cycles got=%0d conflict=%0d want=20,0", pn, conflict); end
    endtask

    task automatic test_halt_at_limit();
        do_run(20);
        checks++; if (rd != 1 || to != 0) begin fails++; $display("FAIL coincide_pulses run_done=%0d timeout=%0d want 1,0", rd, to); end
        checks++; if (cc_done !== 16'd20) begin fails++; $display("FAIL coincide_cycle_count got=%0d want=20", cc_done); end
    endtask

    task automatic test_both_cmd_and_reset();
        do_load(8'h11, 8'h22, 1'b1, 100, 0, 100, 0, 11);
        checks++; if (se_cnt != 11) begin fails++; $display("FAIL both_cmd_shifted got=%0d want=11", se_cnt); end
        checks++; if (pe_seen != 0) begin fails++; $display("FAIL both_cmd_proc_en got=%0d want=0", pe_seen); end
        checks++; if (rst_snap !== 32'h0) begin fails++; $display("FAIL midshift_reset_outputs got=%h want=%h", rst_snap, 32'h0); end
        do_load(8'h33, 8'h44, 1'b0, 100, 0, 100, 0, -1);
        checks++; if (si_bits !== 16'h4433 || se_cnt != 16) begin
            fails++; $display("FAIL reload_scan_in got=%h n=%0d want=4433 n=16", si_bits, se_cnt); end
        checks++; if (ld_cycle != 16 || rb_n != 2) begin
            fails++; $display("FAIL reload_done got=%0d rb_n=%0d want=16,2", ld_cycle, rb_n); end
    endtask

    initial begin
        bus.cmd_load = 1'b0; bus.cmd_run = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        bus.out_ready = 1'b1; bus.halt = 1'b0;
        test_reset();
        test_load_basic();
        test_in_stall();
        test_out_stall();
        test_halt_idle();
        test_run_halt();
        test_run_timeout();
        test_halt_at_limit();
        test_both_cmd_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
